halt_run_ctrl: RTL and testbench

Run controller for the single-core CPU top. Holds the core in reset, releases it on a start pulse, and watches the fetched instruction for either halt encoding. After a halt it drains the pipeline for a fixed cycle count, then reads one result word from data memory through the memory arbiter. It replaces bench-side reset/halt/drain sequencing with synthesizable control, so the same flow runs in RTL, APR and FPGA builds.

---
 rtl/cpu_ctrl_pkg.sv | 24 ++
 rtl/halt_run_ctrl_if.sv | 26 ++
 rtl/ctrl_down_counter.sv | 28 ++
 rtl/halt_run_ctrl.sv | 148 ++++++++++++++
 tb/tb_halt_run_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and helpers for the CPU run controller: halt encodings,
// controller state encoding and the halt decoder.
package cpu_ctrl_pkg;

   localparam logic [15:0] HALT_INSTR_A = 16'hE000;
   localparam logic [15:0] HALT_INSTR_B = 16'hE7FF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RESET,
      ST_RUN,
      ST_DRAIN,
      ST_READ,
      ST_WAIT,
      ST_DONE,
      ST_ERROR
   } run_state_t;

   // Bubbles never count as a halt, even if the instruction bus carries the encoding.
   function automatic logic is_halt(input logic [15:0] instr, input logic instr_valid);
      return instr_valid && ((instr == HALT_INSTR_A) || (instr == HALT_INSTR_B));
   endfunction

endpackage

// File: rtl/halt_run_ctrl_if.sv
// Read-only handshake between the run controller and the data-memory arbiter.
interface halt_run_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_gnt;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_gnt,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_gnt,
      output mem_rdata
   );

endinterface

// File: rtl/ctrl_down_counter.sv
// Loadable down-counter that stops at zero; shared by the reset and drain phases.
module ctrl_down_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         enable,
   output logic         zero
);

   logic [W-1:0] count;

   // Load takes priority so a phase can restart its count on the entry edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/halt_run_ctrl.sv
// Run controller: holds the core in reset, runs it until a halt, drains the
// pipeline and fetches one result word through the data-memory arbiter.
module halt_run_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int RESET_CYCLES   = 4,
   parameter int DRAIN_CYCLES   = 10,
   parameter int MAX_RUN_CYCLES = 65536,
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 16,
   parameter int RESULT_ADDR    = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [15:0]       instr,
   input  logic              instr_valid,
   output logic              core_reset,
   halt_run_ctrl_if.master   mem,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [DATA_W-1:0] result,
   output logic [31:0]       run_cycles
);

   localparam int CNT_MAX = (RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   run_state_t state;
   run_state_t next_state;

   logic             cnt_load;
   logic [CNT_W-1:0] cnt_value;
   logic             cnt_en;
   logic             cnt_zero;
   logic             restart;

   ctrl_down_counter #(
      .W (CNT_W)
   ) u_counter (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (cnt_load),
      .load_value (cnt_value),
      .enable     (cnt_en),
      .zero       (cnt_zero)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   assign restart = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));

   // Next-state and counter control; abort overrides every other transition.
   always_comb begin
      next_state = state;
      cnt_load   = 1'b0;
      cnt_value  = '0;
      cnt_en     = 1'b0;
      case (state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               next_state = ST_RESET;
               cnt_load   = 1'b1;
               cnt_value  = CNT_W'(RESET_CYCLES - 1);
            end
         end
         ST_RESET: begin
            if (cnt_zero) begin
               next_state = ST_RUN;
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_RUN: begin
            if (is_halt(instr, instr_valid)) begin
               next_state = ST_DRAIN;
               cnt_load   = 1'b1;
               cnt_value  = CNT_W'(DRAIN_CYCLES - 1);
            end else if (run_cycles == 32'(MAX_RUN_CYCLES - 1)) begin
               next_state = ST_ERROR;
            end
         end
         ST_DRAIN: begin
            if (cnt_zero) begin
               next_state = ST_READ;
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_READ: begin
            if (mem.mem_gnt) begin
               next_state = ST_WAIT;
            end
         end
         ST_WAIT: begin
            next_state = ST_DONE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
      if (abort) begin
         next_state = ST_IDLE;
         cnt_load   = 1'b0;
         cnt_en     = 1'b0;
      end
   end

   // Cycle statistic: cleared on an accepted start, counts RUN cycles, frozen by abort.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run_cycles <= '0;
      end else if (!abort) begin
         if (restart) begin
            run_cycles <= '0;
         end else if (state == ST_RUN) begin
            run_cycles <= run_cycles + 32'd1;
         end
      end
   end

   // Read data arrives the cycle after the grant, which is exactly the WAIT state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         result <= '0;
      end else if ((state == ST_WAIT) && !abort) begin
         result <= mem.mem_rdata;
      end
   end

   assign core_reset   = (state == ST_IDLE) || (state == ST_RESET) ||
                         (state == ST_DONE) || (state == ST_ERROR);
   assign mem.mem_req  = (state == ST_READ);
   assign mem.mem_addr = (state == ST_READ) ? ADDR_W'(RESULT_ADDR) : '0;
   assign busy         = (state == ST_RESET) || (state == ST_RUN) || (state == ST_DRAIN) ||
                         (state == ST_READ)  || (state == ST_WAIT);
   assign done         = (state == ST_DONE);
   assign timeout      = (state == ST_ERROR);

endmodule

// File: tb/tb_halt_run_ctrl.sv
// Directed bench for halt_run_ctrl: default-parameter instance for the main
// flows and a short-budget instance for the run timeout.
module tb_halt_run_ctrl;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        abort;
   logic [15:0] instr;
   logic        instr_valid;
   logic        core_reset;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [15:0] result;
   logic [31:0] run_cycles;

   logic        start_to;
   logic        abort_to;
   logic [15:0] instr_to;
   logic        instr_valid_to;
   logic        core_reset_to;
   logic        busy_to;
   logic        done_to;
   logic        timeout_to;
   logic [15:0] result_to;
   logic [31:0] run_cycles_to;

   int check_count;
   int error_count;
   int wait_cycles;

   halt_run_ctrl_if #(.ADDR_W(8), .DATA_W(16)) mem_if ();
   halt_run_ctrl_if #(.ADDR_W(8), .DATA_W(16)) mem_if_to ();

   halt_run_ctrl dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .abort       (abort),
      .instr       (instr),
      .instr_valid (instr_valid),
      .core_reset  (core_reset),
      .mem         (mem_if.master),
      .busy        (busy),
      .done        (done),
      .timeout     (timeout),
      .result      (result),
      .run_cycles  (run_cycles)
   );

   halt_run_ctrl #(.MAX_RUN_CYCLES(16)) dut_to (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start_to),
      .abort       (abort_to),
      .instr       (instr_to),
      .instr_valid (instr_valid_to),
      .core_reset  (core_reset_to),
      .mem         (mem_if_to.master),
      .busy        (busy_to),
      .done        (done_to),
      .timeout     (timeout_to),
      .result      (result_to),
      .run_cycles  (run_cycles_to)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Inputs set here are sampled by the next rising edge.
   task automatic applyStimulus(input logic s, input logic a, input logic [15:0] i, input logic v);
      start       = s;
      abort       = a;
      instr       = i;
      instr_valid = v;
      tick();
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " core_reset"}, 32'(core_reset), 32'd1);
      checkOutput({tag, " mem_req"},    32'(mem_if.mem_req), 32'd0);
      checkOutput({tag, " mem_addr"},   32'(mem_if.mem_addr), 32'd0);
      checkOutput({tag, " busy"},       32'(busy), 32'd0);
      checkOutput({tag, " done"},       32'(done), 32'd0);
      checkOutput({tag, " timeout"},    32'(timeout), 32'd0);
      checkOutput({tag, " result"},     32'(result), 32'd0);
      checkOutput({tag, " run_cycles"}, run_cycles, 32'd0);
   endtask

   task automatic startToRun();
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      repeat (4) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
   endtask

   initial begin
      check_count       = 0;
      error_count       = 0;
      reset_n           = 1'b0;
      start             = 1'b0;
      abort             = 1'b0;
      instr             = 16'h0000;
      instr_valid       = 1'b0;
      mem_if.mem_gnt    = 1'b0;
      mem_if.mem_rdata  = 16'h0000;
      start_to          = 1'b0;
      abort_to          = 1'b0;
      instr_to          = 16'h0000;
      instr_valid_to    = 1'b0;
      mem_if_to.mem_gnt = 1'b0;
      mem_if_to.mem_rdata = 16'h0000;

      repeat (3) tick();
      checkResetValues("por");
      reset_n = 1'b1;
      tick();

      // Start sequencing and first run with a halt on the 20th RUN cycle.
      mem_if.mem_gnt = 1'b1;
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("reset phase core_reset %0d", i), 32'(core_reset), 32'd1);
         checkOutput($sformatf("reset phase busy %0d", i), 32'(busy), 32'd1);
         applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      end
      checkOutput("run core_reset", 32'(core_reset), 32'd0);
      repeat (19) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'hE000, 1'b1);
      checkOutput("halt A run_cycles", run_cycles, 32'd20);
      for (int i = 0; i < 10; i++) begin
         checkOutput($sformatf("drain mem_req %0d", i), 32'(mem_if.mem_req), 32'd0);
         applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      end
      checkOutput("read mem_req", 32'(mem_if.mem_req), 32'd1);
      checkOutput("read mem_addr", 32'(mem_if.mem_addr), 32'd1);
      mem_if.mem_rdata = 16'h3C00;
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checkOutput("wait mem_req", 32'(mem_if.mem_req), 32'd0);
      checkOutput("wait done", 32'(done), 32'd0);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checkOutput("run1 result", 32'(result), 32'h3C00);
      checkOutput("run1 done", 32'(done), 32'd1);
      checkOutput("run1 busy", 32'(busy), 32'd0);
      checkOutput("run1 core_reset", 32'(core_reset), 32'd1);
      checkOutput("run1 run_cycles", run_cycles, 32'd20);

      // Halt encoding B as a bubble first, then valid; grant delayed 5 cycles.
      mem_if.mem_gnt = 1'b0;
      startToRun();
      repeat (3) applyStimulus(1'b0, 1'b0, 16'hE7FF, 1'b0);
      checkOutput("bubble halt ignored", run_cycles, 32'd3);
      applyStimulus(1'b0, 1'b0, 16'hE7FF, 1'b1);
      checkOutput("halt B run_cycles", run_cycles, 32'd4);
      repeat (10) applyStimulus(1'b0, 1'b0, 16'hE000, 1'b1);
      checkOutput("drain ignores instr", run_cycles, 32'd4);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("stall mem_req %0d", i), 32'(mem_if.mem_req), 32'd1);
         checkOutput($sformatf("stall done %0d", i), 32'(done), 32'd0);
         applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      end
      mem_if.mem_gnt   = 1'b1;
      mem_if.mem_rdata = 16'hA5A5;
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      mem_if.mem_gnt = 1'b0;
      checkOutput("run2 wait mem_req", 32'(mem_if.mem_req), 32'd0);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checkOutput("run2 result", 32'(result), 32'hA5A5);
      checkOutput("run2 done", 32'(done), 32'd1);
      checkOutput("run2 run_cycles", run_cycles, 32'd4);

      // Abort in DRAIN, then abort together with start.
      startToRun();
      applyStimulus(1'b0, 1'b0, 16'hE000, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checkOutput("drain busy", 32'(busy), 32'd1);
      applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0);
      checkOutput("abort core_reset", 32'(core_reset), 32'd1);
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort done", 32'(done), 32'd0);
      checkOutput("abort mem_req", 32'(mem_if.mem_req), 32'd0);
      checkOutput("abort result kept", 32'(result), 32'hA5A5);
      checkOutput("abort run_cycles kept", run_cycles, 32'd1);
      applyStimulus(1'b1, 1'b1, 16'h0000, 1'b0);
      checkOutput("abort+start busy", 32'(busy), 32'd0);
      checkOutput("abort+start core_reset", 32'(core_reset), 32'd1);
      checkOutput("abort+start run_cycles", run_cycles, 32'd1);

      // Asynchronous reset while the read request is pending.
      startToRun();
      applyStimulus(1'b0, 1'b0, 16'hE000, 1'b1);
      repeat (10) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checkOutput("pre-reset mem_req", 32'(mem_if.mem_req), 32'd1);
      #2 reset_n = 1'b0;
      #1 checkResetValues("async");
      #2 reset_n = 1'b1;
      tick();

      // Run budget of 16 cycles with no halt.
      start_to = 1'b1;
      tick();
      start_to = 1'b0;
      wait_cycles = 0;
      while (!timeout_to && (wait_cycles < 100)) begin
         tick();
         wait_cycles++;
      end
      checkOutput("timeout latency", 32'(wait_cycles), 32'd20);
      checkOutput("timeout flag", 32'(timeout_to), 32'd1);
      checkOutput("timeout run_cycles", run_cycles_to, 32'd16);
      checkOutput("timeout core_reset", 32'(core_reset_to), 32'd1);
      checkOutput("timeout busy", 32'(busy_to), 32'd0);
      start_to = 1'b1;
      tick();
      start_to = 1'b0;
      checkOutput("restart run_cycles", run_cycles_to, 32'd0);
      checkOutput("restart busy", 32'(busy_to), 32'd1);
      checkOutput("restart timeout", 32'(timeout_to), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
